// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad front end for the dual seven-segment path.
// It drives one column low at a time and synchronizes and debounces the rows. One
// key per press is decoded to a hex code, and the last two keys are kept as
// s_left/s_right.
// Optional build macro: KEYPAD_AUTOREPEAT_EN. When defined, a held key re-fires
// the accept update every REPEAT_TICKS scan ticks.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV_EXP   = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_TICKS   = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] s_left,
  output logic [3:0] s_right
);

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StPressed,
    StReleaseDb
  } state_e;

  localparam logic [3:0] DebTarget = 4'(DEBOUNCE_SCANS);

  // Reject parameter values that would break the counters at elaboration time.
  if (SCAN_DIV_EXP < 1) begin : g_bad_scan_div
    $error("SCAN_DIV_EXP must be at least 1");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be in 1..15");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("REPEAT_TICKS must be at least 1");
  end

  logic [3:0]              rows_meta_q;
  logic [3:0]              rsync_q;
  logic [SCAN_DIV_EXP-1:0] div_q;
  logic                    tick;

  state_e     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [3:0] db_q, db_d;
  logic [1:0] hit_row;
  logic       hit;
  logic       row_high;
  logic       accept;
  logic [3:0] accept_code;

  logic       key_valid_q;
  logic [3:0] key_code_q;
  logic [3:0] s_left_q;
  logic [3:0] s_right_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepTarget = RepW'(REPEAT_TICKS);
  logic [RepW-1:0] rep_q, rep_d;
`endif

  // Two-flop synchronizer; idles at all-ones (no key) out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_q <= 4'hF;
      rsync_q     <= 4'hF;
    end else begin
      rows_meta_q <= rows;
      rsync_q     <= rows_meta_q;
    end
  end

  // Free-running scan divider; the tick strobe marks the cycle before it wraps to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + SCAN_DIV_EXP'(1);
    end
  end

  assign tick = &div_q;

  // Lowest-index low row wins when several rows are low together.
  always_comb begin
    hit_row = 2'd3;
    if (!rsync_q[0]) begin
      hit_row = 2'd0;
    end else if (!rsync_q[1]) begin
      hit_row = 2'd1;
    end else if (!rsync_q[2]) begin
      hit_row = 2'd2;
    end
  end

  assign hit      = (rsync_q != 4'hF);
  assign row_high = rsync_q[row_q];

  // Keypad legend lookup for the captured row and the frozen column.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  assign accept_code = key_map(row_q, col_q);

  // Scan/debounce next state; everything moves only on a tick.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    db_d    = db_q;
    accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d   = rep_q;
`endif
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (hit) begin
            row_d   = hit_row;
            db_d    = 4'd0;
            state_d = StPressDb;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        StPressDb: begin
          if (!row_high) begin
            db_d = db_q + 4'd1;
            if (db_d == DebTarget) begin
              state_d = StPressed;
              accept  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d   = '0;
`endif
            end
          end else begin
            // Bounce during the press: give up and keep scanning.
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end
        end
        StPressed: begin
          if (row_high) begin
            db_d    = 4'd0;
            state_d = StReleaseDb;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d = rep_q + RepW'(1);
            if (rep_d == RepTarget) begin
              rep_d  = '0;
              accept = 1'b1;
            end
`endif
          end
        end
        StReleaseDb: begin
          if (row_high) begin
            db_d = db_q + 4'd1;
            if (db_d == DebTarget) begin
              state_d = StScan;
              col_d   = col_q + 2'd1;
            end
          end else begin
            // Bounce or re-press of the same key: still the same press.
            state_d = StPressed;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end
        end
        default: begin
          state_d = StScan;
        end
      endcase
    end
  end

  // Scanner state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StScan;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      db_q    <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      db_q    <= db_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Accept update: new digit enters on the right, previous right digit shifts left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      s_left_q    <= 4'h0;
      s_right_q   <= 4'h0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= accept_code;
        s_right_q  <= accept_code;
        s_left_q   <= s_right_q;
      end
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == StPressed) || (state_q == StReleaseDb);
  assign s_left    = s_left_q;
  assign s_right   = s_right_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Small parameters: a tick every 4 clk and 3 debounce ticks. The debounce ticks are the
// ticks after the one that first sees the key.
module tb_keypad_scanner;

  localparam int unsigned ScanDivExp    = 2;
  localparam int unsigned DebounceScans = 3;
  localparam int unsigned RepeatTicks   = 5;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int   ExpHoldPulses = 4;  // accept + repeats at 5, 10, 15 held ticks
  localparam logic ExpRepPulse   = 1'b1;
  localparam int   ExpRepCount   = 3;
`else
  localparam int   ExpHoldPulses = 1;
  localparam logic ExpRepPulse   = 1'b0;
  localparam int   ExpRepCount   = 1;
`endif

  localparam int K3 = 0 * 4 + 2;
  localparam int KA = 0 * 4 + 3;
  localparam int K5 = 1 * 4 + 1;
  localparam int KD = 3 * 4 + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [3:0]  s_left;
  logic [3:0]  s_right;
  logic [15:0] key_down;

  int n_checks  = 0;
  int n_pass    = 0;
  int valid_cnt = 0;
  int snap;

  keypad_scanner #(
    .SCAN_DIV_EXP  (ScanDivExp),
    .DEBOUNCE_SCANS(DebounceScans),
    .REPEAT_TICKS  (RepeatTicks)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .s_left   (s_left),
    .s_right  (s_right)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  // Count every cycle key_valid is high, so a stretched pulse counts twice.
  always @(negedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to just after the next scan-tick edge (ticks land every 4th edge after release).
  task automatic tick_step(input int n);
    repeat (n * 4) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [3:0] walk_exp [4];

  initial begin
    reset    = 1'b1;
    key_down = 16'h0;
    walk_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_cols", cols, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_left", s_left, 4'h0);
    check("rst_right", s_right, 4'h0);
    reset = 1'b0;

    // Idle column walk, one step per tick.
    for (int i = 0; i < 4; i++) begin
      tick_step(1);
      check("cols_walk", cols, walk_exp[i]);
    end

    // Clean press of '5' from column 0.
    snap = valid_cnt;
    key_down[K5] = 1'b1;
    tick_step(1);                       // column 1 reached
    check("p5_cols", cols, 4'b1101);
    tick_step(1);                       // detect -> press debounce
    check("p5_detect_held", key_held, 1'b0);
    tick_step(2);                       // debounce ticks 1, 2
    check("p5_early_valid", key_valid, 1'b0);
    tick_step(1);                       // debounce tick 3 -> accept
    check("p5_valid", key_valid, 1'b1);
    check("p5_code", key_code, 4'h5);
    check("p5_right", s_right, 4'h5);
    check("p5_left", s_left, 4'h0);
    check("p5_held", key_held, 1'b1);
    tick_step(19);
    check("p5_hold_cols", cols, 4'b1101);
    check("p5_hold_held", key_held, 1'b1);
    check("p5_pulses", valid_cnt - snap, ExpHoldPulses);

    // Release with bounce: high 2, low 1, high 5.
    key_down[K5] = 1'b0;
    tick_step(2);
    key_down[K5] = 1'b1;
    tick_step(1);                       // bounce back to pressed
    check("rel_bounce_held", key_held, 1'b1);
    key_down[K5] = 1'b0;
    tick_step(3);                       // leave pressed, release debounce 1, 2
    check("rel_db_held", key_held, 1'b1);
    tick_step(1);                       // release debounce 3 -> scan, column 2
    check("rel_done_held", key_held, 1'b0);
    check("rel_done_cols", cols, 4'b1011);
    tick_step(1);
    check("rel_cols_next", cols, 4'b0111);
    check("rel_pulses", valid_cnt - snap, ExpHoldPulses);

    // Bouncy press: low for the detect tick, high for the next, then held.
    apply_reset();
    snap = valid_cnt;
    key_down[K5] = 1'b1;
    tick_step(1);
    check("bnc_cols", cols, 4'b1101);
    tick_step(1);                       // detect
    key_down[K5] = 1'b0;
    tick_step(1);                       // bounce -> scan, column 2
    check("bnc_abort_cols", cols, 4'b1011);
    check("bnc_abort_held", key_held, 1'b0);
    key_down[K5] = 1'b1;
    tick_step(3);                       // columns 3, 0, 1
    check("bnc_back_cols", cols, 4'b1101);
    check("bnc_no_pulse", valid_cnt - snap, 0);
    tick_step(4);                       // detect + 3 debounce ticks
    check("bnc_valid", key_valid, 1'b1);
    check("bnc_code", key_code, 4'h5);
    tick_step(1);
    check("bnc_pulses", valid_cnt - snap, 1);

    // Sequence '3' then 'D', with 'A' pressed while '3' is held.
    key_down = 16'h0;
    apply_reset();
    snap = valid_cnt;
    key_down[K3] = 1'b1;
    tick_step(6);                       // columns 1, 2, detect, 3 debounce ticks
    check("s3_valid", key_valid, 1'b1);
    check("s3_code", key_code, 4'h3);
    check("s3_left", s_left, 4'h0);
    check("s3_right", s_right, 4'h3);
    key_down[KA] = 1'b1;
    tick_step(3);
    check("sa_cols", cols, 4'b1011);
    check("sa_code", key_code, 4'h3);
    check("sa_right", s_right, 4'h3);
    check("sa_left", s_left, 4'h0);
    check("sa_pulses", valid_cnt - snap, 1);
    key_down = 16'h0;
    tick_step(4);                       // release debounce -> scan, column 3
    check("sd_scan_held", key_held, 1'b0);
    check("sd_scan_cols", cols, 4'b0111);
    key_down[KD] = 1'b1;
    tick_step(4);                       // detect + 3 debounce ticks
    check("sd_valid", key_valid, 1'b1);
    check("sd_code", key_code, 4'hD);
    check("sd_left", s_left, 4'h3);
    check("sd_right", s_right, 4'hD);

    // Reset while '5' sits in press debounce.
    key_down = 16'h0;
    tick_step(4);                       // release debounce -> scan, column 0
    key_down[K5] = 1'b1;
    tick_step(3);                       // column 1, detect, debounce tick 1
    reset = 1'b1;
    #1;
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_left", s_left, 4'h0);
    check("mid_rst_right", s_right, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_cols", cols, 4'b1110);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    snap = valid_cnt;
    tick_step(5);                       // column 1, detect, 3 debounce ticks
    check("re_valid", key_valid, 1'b1);
    check("re_code", key_code, 4'h5);
    check("re_right", s_right, 4'h5);
    check("re_left", s_left, 4'h0);
    tick_step(5);
    check("rep_pulse1", key_valid, ExpRepPulse);
    tick_step(5);
    check("rep_pulse2", key_valid, ExpRepPulse);
    tick_step(1);
    check("rep_pulses", valid_cnt - snap, ExpRepCount);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
